// File: rtl/stopwatch_counter_pkg.sv
// Shared constants and helpers for the stopwatch MM:SS counter.
package stopwatch_counter_pkg;

  // Largest legal value of a units digit and of a tens digit.
  localparam logic [3:0] DIG_MAX_UNITS = 4'd9;
  localparam logic [3:0] DIG_MAX_TENS  = 4'd5;

  // Bits needed to hold the values 0..v-1.
  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit_counter.sv
// One BCD digit: a mod-(MAX+1) counter with a carry in and a carry out.
module bcd_digit_counter
  import stopwatch_counter_pkg::*;
#(
  parameter logic [3:0] MAX = DIG_MAX_UNITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] r_q;

  // The carry is combinational so the whole chain settles in the same cycle.
  assign carry = inc & (r_q == MAX);
  assign q     = r_q;

  // Digit register: clear wins, otherwise step and roll over at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_q <= 4'd0;
    else if (clr)     r_q <= 4'd0;
    else if (inc)     r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: divides clk to a seconds tick while enabled and
// advances an MM:SS BCD value. Pausing keeps the partial-second count.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = 40000000,
  parameter int unsigned DIV_W    = clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_enable,
  input  logic       clr,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic       tick,
  output logic       wrap
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_presc;
  logic             r_tick;
  logic             r_wrap;

  logic w_term;
  logic w_c_sec0;
  logic w_c_sec1;
  logic w_c_min0;
  logic w_c_min1;

  // A terminal edge ends a counted second; it only happens while enabled.
  assign w_term = cnt_enable & (r_presc == PRESC_LAST);

  // Prescaler: advances only when enabled and holds across a pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_presc <= '0;
    else if (clr)        r_presc <= '0;
    else if (cnt_enable) r_presc <= w_term ? '0 : r_presc + 1'b1;
  end

  // tick/wrap land on the same edge as the new digits; clear suppresses both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_term & ~clr;
      r_wrap <= w_c_min1 & ~clr;
    end
  end

  bcd_digit_counter #(.MAX(DIG_MAX_UNITS)) u_sec0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(w_term),
    .q(sec0), .carry(w_c_sec0)
  );

  bcd_digit_counter #(.MAX(DIG_MAX_TENS)) u_sec1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(w_c_sec0),
    .q(sec1), .carry(w_c_sec1)
  );

  bcd_digit_counter #(.MAX(DIG_MAX_UNITS)) u_min0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(w_c_sec1),
    .q(min0), .carry(w_c_min0)
  );

  // Carry out of the top digit marks the 59:59 -> 00:00 rollover.
  bcd_digit_counter #(.MAX(DIG_MAX_TENS)) u_min1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(w_c_min0),
    .q(min1), .carry(w_c_min1)
  );

  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed table-driven bench for stopwatch_counter with TICK_DIV=4.
module tb_stopwatch_counter;

  logic       clk;
  logic       rst_n;
  logic       cnt_enable;
  logic       clr;
  logic [3:0] sec0, sec1, min0, min1;
  logic       tick, wrap;

  int checks = 0;
  int errors = 0;
  int tick_cnt;

  stopwatch_counter #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_enable(cnt_enable), .clr(clr),
    .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
    .tick(tick), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table entry: hold (en, clr) for reps cycles, then check outputs.
  // time_bcd is {min1,min0,sec1,sec0}; ticks is the tick count over the run.
  typedef struct {
    string       name;
    logic        en;
    logic        clr;
    int          reps;
    int          ticks;
    logic [15:0] time_bcd;
    logic        tick;
    logic        wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic en, input logic c, input int reps,
                     input int ticks, input logic [15:0] t, input logic tk, input logic wr);
    vec_t v;
    v.name = n; v.en = en; v.clr = c; v.reps = reps; v.ticks = ticks;
    v.time_bcd = t; v.tick = tk; v.wrap = wr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", n, got, exp);
    end
  endtask

  // Advance one clock with the given inputs; sample 1 time unit after the edge.
  task automatic step(input logic en, input logic c);
    cnt_enable = en;
    clr        = c;
    @(posedge clk);
    #1;
    if (tick === 1'b1) tick_cnt++;
  endtask

  function automatic logic [15:0] cur_time();
    return {min1, min0, sec1, sec0};
  endfunction

  initial begin
    cnt_enable = 1'b0;
    clr        = 1'b0;
    rst_n      = 1'b0;

    // idle and basic counting
    add("idle20",      0, 0, 20,    0,    16'h0000, 0, 0);
    add("cnt3",        1, 0, 3,     0,    16'h0000, 0, 0);
    add("cnt4_tick",   1, 0, 1,     1,    16'h0001, 1, 0);
    add("cnt40",       1, 0, 36,    9,    16'h0010, 1, 0);
    // pause / resume
    add("clr_pre",     0, 1, 1,     0,    16'h0000, 0, 0);
    add("en6",         1, 0, 6,     1,    16'h0001, 0, 0);
    add("pause10",     0, 0, 10,    0,    16'h0001, 0, 0);
    add("resume1",     1, 0, 1,     0,    16'h0001, 0, 0);
    add("resume2",     1, 0, 1,     1,    16'h0002, 1, 0);
    // clear on a terminal edge
    add("to_term",     1, 0, 3,     0,    16'h0002, 0, 0);
    add("clr_term",    1, 1, 1,     0,    16'h0000, 0, 0);
    add("post_clr3",   1, 0, 3,     0,    16'h0000, 0, 0);
    add("post_clr4",   1, 0, 1,     1,    16'h0001, 1, 0);
    // wrap at 59:59
    add("clr_wrap",    0, 1, 1,     0,    16'h0000, 0, 0);
    add("to_5959",     1, 0, 3599*4, 3599, 16'h5959, 1, 0);
    add("wrap",        1, 0, 4,     1,    16'h0000, 1, 1);
    add("after_wrap",  1, 0, 4,     1,    16'h0001, 1, 0);
    // clear while paused at 12:34
    add("clr_1234",    0, 1, 1,     0,    16'h0000, 0, 0);
    add("to_1234",     1, 0, 3016,  754,  16'h1234, 1, 0);
    add("hold_1234",   0, 0, 1,     0,    16'h1234, 0, 0);
    add("clr_paused",  0, 1, 1,     0,    16'h0000, 0, 0);
    add("to_0007",     1, 0, 28,    7,    16'h0007, 1, 0);

    // reset state
    #12;
    chk("reset_time", {16'h0, cur_time()}, 32'h0);
    chk("reset_tick", {30'h0, tick, wrap}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      tick_cnt = 0;
      for (int r = 0; r < vecs[i].reps; r++) step(vecs[i].en, vecs[i].clr);
      chk({vecs[i].name, "_time"},  {16'h0, cur_time()}, {16'h0, vecs[i].time_bcd});
      chk({vecs[i].name, "_tkwr"},  {30'h0, tick, wrap}, {30'h0, vecs[i].tick, vecs[i].wrap});
      chk({vecs[i].name, "_ticks"}, tick_cnt, vecs[i].ticks);
    end

    // Mid-count async reset: two more enabled cycles (prescaler=2), then
    // drop rst_n between edges and check outputs without a clock edge.
    step(1, 0);
    step(1, 0);
    chk("pre_rst_time", {16'h0, cur_time()}, 32'h0007);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_time", {16'h0, cur_time()}, 32'h0);
    chk("async_rst_tkwr", {30'h0, tick, wrap}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_cnt = 0;
    for (int r = 0; r < 3; r++) step(1, 0);
    chk("rel3_time",  {16'h0, cur_time()}, 32'h0);
    chk("rel3_ticks", tick_cnt, 0);
    step(1, 0);
    chk("rel4_time", {16'h0, cur_time()}, 32'h0001);
    chk("rel4_tick", {31'h0, tick}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Downstream consumer of the stopwatch start/stop FSM's cnt_enable output. Divides clk down to a seconds tick. While enabled, advances an MM:SS BCD time value (00:00 to 59:59) and drives the digit values to the 7-segment display scanner. Pausing keeps both the displayed time and the partial-second prescaler state, so resume is seamless.

Parameters:
TICK_DIV, 40000000, clk cycles per counted second (>=2); benches use 4
DIV_W, 26, prescaler width; must satisfy 2**DIV_W >= TICK_DIV

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
cnt_enable  input  1  count enable from the start/stop FSM; level, synchronous to clk
clr  input  1  synchronous clear, active-high, level
sec0  output  4  BCD seconds units, 0-9
sec1  output  4  BCD seconds tens, 0-5
min0  output  4  BCD minutes units, 0-9
min1  output  4  BCD minutes tens, 0-5
tick  output  1  one-cycle pulse; high in the first cycle the new digit values are visible
wrap  output  1  one-cycle pulse, coincident with tick, when the time rolls 59:59 -> 00:00

Behaviour:
- All state and outputs are registers.
- Reset (rst_n=0, asynchronous): prescaler=0, all digits=0, tick=0, wrap=0.
- Prescaler:
  - counts 0..TICK_DIV-1 only on cycles with cnt_enable=1.
  - holds its value when cnt_enable=0; it is not cleared on pause.
- Terminal edge: an edge where prescaler==TICK_DIV-1 and cnt_enable=1.
  - prescaler -> 0.
  - time increments by one second.
  - tick <= 1 on the same edge, so tick and the new digits appear together.
- Latency: with a continuous enable from prescaler=0, the first tick is visible TICK_DIV cycles after the first enabled edge; after that, one tick every TICK_DIV cycles.
- tick and wrap are 0 on every edge that is not a terminal edge.
- Increment chain (each digit is a mod-N counter with carry-in and carry-out):
  - sec0 mod 10, carry-in = terminal.
  - sec1 mod 6, carry-in = terminal & sec0==9.
  - min0 mod 10, carry-in = the above & sec1==5.
  - min1 mod 6, carry-in = the above & min0==9.
- Wrap:
  - at 59:59, a terminal edge gives 00:00 and wrap=1 (with tick=1).
  - counting continues afterwards; there is no saturation.
- clr=1: next edge forces prescaler=0, digits=0, tick=0, wrap=0.
  - clr has priority over a simultaneous terminal edge; no tick is emitted.
  - clr works regardless of cnt_enable.
- cnt_enable toggling mid-second: partial progress is preserved; ticks resume after the remaining (TICK_DIV - prescaler) enabled cycles.
- Reset asserted mid-count: immediate return to the reset values; no tick or wrap pulse is generated.
- Digit values are never outside their legal range; no illegal-state recovery is needed beyond the reset and clr paths.

Decomposition:
- Shared package/header: BCD limit constants (DIG_MAX_UNITS=9, DIG_MAX_TENS=5) and a clog2 helper for deriving DIV_W.
- One sub-module: bcd_digit_counter.
  - parameter MAX; ports clk, rst_n, clr, inc, q[3:0], carry.
  - carry = inc & (q==MAX), combinational.
  - inc at q==MAX gives q=0.
- Instantiated four times (MAX = 9, 5, 9, 5). The top holds the prescaler, the tick/wrap registers and the carry chain.

Test Plan:
1. TICK_DIV=4. Assert reset, then release with cnt_enable=0 for 20 cycles -> all digits 0, tick=0 and wrap=0 throughout.
2. cnt_enable=1 for 40 cycles -> tick pulses on cycles 4, 8, ... 40 (10 pulses). Final state: sec1=1, sec0=0, min=00.
3. Pause and resume:
   - enable 6 cycles -> 1 tick, prescaler=2.
   - disable 10 cycles -> no tick, digits stay 00:01.
   - re-enable -> tick on the 2nd enabled cycle, time 00:02.
4. Wrap: enable continuously for 3599*4 cycles -> 59:59, wrap=0. Four more cycles -> 00:00 with tick=1 and wrap=1 in the same cycle; the next tick gives 00:01 with wrap=0.
5. Simultaneous events:
   - clr=1 on a terminal edge -> 00:00, tick=0, and the next tick comes 4 enabled cycles later.
   - clr=1 with cnt_enable=0 at 12:34 -> 00:00.
6. Mid-count reset: assert rst_n=0 asynchronously (between clk edges) at 00:07 -> outputs 0 immediately without a clk edge. After release with enable held, the first tick comes 4 cycles later, at 00:01.
